clkdiv_ratio_ctrl: RTL and testbench
====================================

CLKDIV_RATIO_CTRL -- requirements
Module: clkdiv_ratio_ctrl

Interface
REQ-001 SHALL have parameter WIDTH, default 8, meaning width of the applied division ratio.
REQ-002 SHALL have port CLK  input  1  system clock; all state updates on rising edge.
REQ-003 SHALL have port RST  input  1  reset; asynchronous and active-high.
REQ-004 SHALL have port EN  input  1  divider enable; low holds the divider idle.
REQ-005 SHALL have port CFG_PRESCALE  input  6  one-hot prescale code for the requested ratio.
REQ-006 SHALL have port CFG_VALID  input  1  request to load CFG_PRESCALE.
REQ-007 SHALL have port CFG_READY  output  1  high when a new request can be accepted.
REQ-008 SHALL have port DIV_RATIO  output  WIDTH  currently applied ratio, registered.
REQ-009 SHALL have port TICK  output  1  one-cycle pulse once per DIV_RATIO enabled cycles.
REQ-010 SHALL have port CFG_ERR  output  1  one-cycle pulse flagging an accepted invalid code.

Function
REQ-011 SHALL decode CFG_PRESCALE as: 100000->1, 010000->2, 001000->4, 000100->8, any other value->1, zero-extended to WIDTH.
REQ-012 SHALL hold a registered 3-state FSM: IDLE, RUN, PEND; plus counter CNT (WIDTH bits) and shadow ratio SHD (WIDTH bits).
REQ-013 SHALL drive TICK = (state is RUN or PEND) and EN and (CNT == DIV_RATIO-1), decoded from registered state only.
REQ-014 SHALL drive CFG_READY = (state != PEND); accept a request when CFG_VALID and CFG_READY are both high at a clock edge.
REQ-015 SHALL ignore CFG_VALID while CFG_READY is low: no state change, no CFG_ERR.
REQ-016 IDLE: EN=1 at edge -> RUN, CNT=0; EN=0 -> stay IDLE, CNT=0; accepted request -> DIV_RATIO=decoded ratio at that same edge.
REQ-017 RUN: EN=0 at edge -> IDLE, CNT=0; else TICK=1 -> CNT=0, otherwise CNT=CNT+1.
REQ-018 RUN with accepted request and TICK=1 in the same cycle -> DIV_RATIO=decoded ratio, CNT=0, stay RUN.
REQ-019 RUN with accepted request and TICK=0 -> SHD=decoded ratio, -> PEND, DIV_RATIO unchanged, counting continues.
REQ-020 PEND: TICK=1 at edge -> DIV_RATIO=SHD, CNT=0, -> RUN; EN=0 at edge -> DIV_RATIO=SHD, CNT=0, -> IDLE (EN=0 has priority only in that no TICK occurs).
REQ-021 SHALL therefore never change DIV_RATIO mid-period while EN is high; every TICK period is a whole period of a single ratio.
REQ-022 With DIV_RATIO=1, TICK SHALL be high every cycle in RUN/PEND with EN=1.
REQ-023 CFG_ERR SHALL pulse high for exactly the cycle after an accepted request whose code is not one of the four valid one-hot codes.
REQ-024 First TICK after EN rises (sampled at edge k in IDLE) SHALL occur in cycle k+DIV_RATIO.

Reset
REQ-025 On RST=1, asynchronously: state=IDLE, CNT=0, SHD=1, DIV_RATIO=1, CFG_ERR=0; thus TICK=0, CFG_READY=1.
REQ-026 Reset asserted in PEND SHALL discard SHD; no pending ratio survives reset.
REQ-027 After RST falls, first edge SHALL be handled as IDLE per REQ-016.

Verification
REQ-028 Reset, EN=0, request 001000 -> DIV_RATIO=4 next cycle, TICK stays 0, CFG_READY=1.
REQ-029 DIV_RATIO=4, EN held high from edge k -> TICK in cycles k+4, k+8, k+12, each one cycle wide.
REQ-030 DIV_RATIO=8 running, request 010000 at CNT=2 -> CFG_READY=0, TICK at CNT=7 still with ratio 8, then DIV_RATIO=2, TICKs every 2 cycles, CFG_READY=1.
REQ-031 Request 100000 coincident with TICK in RUN -> DIV_RATIO=1 immediately, TICK every following cycle, no PEND entry; second request while PEND -> ignored.
REQ-032 Request code 110000 accepted -> DIV_RATIO=1, CFG_ERR high one cycle; request 000000 likewise.
REQ-033 RST pulsed in PEND with SHD=8 and EN=1 -> DIV_RATIO=1, state IDLE, no TICK until EN sampled again per REQ-024.

Source files
------------

// File: rtl/clkdiv_ratio_ctrl.sv
// Programmable tick divider whose one-hot ratio requests only take effect on a period boundary.
// TICK is decoded from registered state with no extra latency; CFG_READY drops while a ratio change is pending.
module clkdiv_ratio_ctrl #(
  parameter int WIDTH = 8
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             EN,
  input  logic [5:0]       CFG_PRESCALE,
  input  logic             CFG_VALID,
  output logic             CFG_READY,
  output logic [WIDTH-1:0] DIV_RATIO,
  output logic             TICK,
  output logic             CFG_ERR
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    PEND = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0] shd_q, shd_d;
  logic [WIDTH-1:0] ratio_q, ratio_d;
  logic             err_q, err_d;

  logic [WIDTH-1:0] dec_ratio;
  logic             dec_ok;
  logic             accept;
  logic             tick;
  logic [WIDTH-1:0] ratio_m1;

  // Anything that is not one of the four one-hot codes falls back to ratio 1 and is flagged.
  always_comb begin
    dec_ratio = WIDTH'(1);
    dec_ok    = 1'b1;
    case (CFG_PRESCALE)
      6'b100000: dec_ratio = WIDTH'(1);
      6'b010000: dec_ratio = WIDTH'(2);
      6'b001000: dec_ratio = WIDTH'(4);
      6'b000100: dec_ratio = WIDTH'(8);
      default:   dec_ok    = 1'b0;
    endcase
  end

  assign ratio_m1  = ratio_q - WIDTH'(1);
  assign tick      = (state_q != IDLE) && EN && (cnt_q == ratio_m1);
  assign CFG_READY = (state_q != PEND);
  assign accept    = CFG_VALID && CFG_READY;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    shd_d   = shd_q;
    ratio_d = ratio_q;
    err_d   = accept && !dec_ok;
    case (state_q)
      IDLE: begin
        cnt_d   = '0;
        state_d = EN ? RUN : IDLE;
        if (accept) ratio_d = dec_ratio;
      end
      RUN: begin
        if (!EN) begin
          // No period is in progress once disabled, so a request can land directly.
          state_d = IDLE;
          cnt_d   = '0;
          if (accept) ratio_d = dec_ratio;
        end else if (tick) begin
          cnt_d = '0;
          if (accept) ratio_d = dec_ratio;
        end else begin
          cnt_d = cnt_q + WIDTH'(1);
          if (accept) begin
            shd_d   = dec_ratio;
            state_d = PEND;
          end
        end
      end
      PEND: begin
        if (!EN) begin
          ratio_d = shd_q;
          cnt_d   = '0;
          state_d = IDLE;
        end else if (tick) begin
          ratio_d = shd_q;
          cnt_d   = '0;
          state_d = RUN;
        end else begin
          cnt_d = cnt_q + WIDTH'(1);
        end
      end
      default: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      shd_q   <= WIDTH'(1);
      ratio_q <= WIDTH'(1);
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      shd_q   <= shd_d;
      ratio_q <= ratio_d;
      err_q   <= err_d;
    end
  end

  assign DIV_RATIO = ratio_q;
  assign TICK      = tick;
  assign CFG_ERR   = err_q;

endmodule

// File: tb/tb_clkdiv_ratio_ctrl.sv
// Vector-table bench for clkdiv_ratio_ctrl with a scoreboard queue of expected outputs.
module tb_clkdiv_ratio_ctrl;

  logic       CLK = 1'b0;
  logic       RST = 1'b1;
  logic       EN = 1'b0;
  logic       CFG_VALID = 1'b0;
  logic [5:0] CFG_PRESCALE = 6'b0;
  logic       CFG_READY;
  logic [7:0] DIV_RATIO;
  logic       TICK;
  logic       CFG_ERR;

  clkdiv_ratio_ctrl #(.WIDTH(8)) dut (
    .CLK(CLK),
    .RST(RST),
    .EN(EN),
    .CFG_PRESCALE(CFG_PRESCALE),
    .CFG_VALID(CFG_VALID),
    .CFG_READY(CFG_READY),
    .DIV_RATIO(DIV_RATIO),
    .TICK(TICK),
    .CFG_ERR(CFG_ERR)
  );

  always #5 CLK = ~CLK;

  typedef struct {
    logic       rst;
    logic       en;
    logic       vld;
    logic [5:0] pre;
    logic       tick;
    logic       rdy;
    logic [7:0] ratio;
    logic       err;
  } vec_t;

  typedef struct {
    logic       tick;
    logic       rdy;
    logic [7:0] ratio;
    logic       err;
    int         idx;
  } exp_t;

  exp_t sb[$];
  int   n_chk  = 0;
  int   n_pass = 0;
  int   step   = 0;
  vec_t tbl[31];

  function automatic vec_t mk(input int r, input int e, input int va, input int p,
                              input int t, input int rd, input int ra, input int er);
    vec_t v;
    v.rst   = (r != 0);
    v.en    = (e != 0);
    v.vld   = (va != 0);
    v.pre   = 6'(p);
    v.tick  = (t != 0);
    v.rdy   = (rd != 0);
    v.ratio = 8'(ra);
    v.err   = (er != 0);
    return v;
  endfunction

  task automatic chk(input string name, input int idx, input logic [7:0] act, input logic [7:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s step %0d: got %0d expected %0d", name, idx, act, exp);
  endtask

  // Drive one vector at the falling edge, let one rising edge pass, compare at the next falling edge.
  task automatic apply(input vec_t v);
    exp_t e;
    RST          = v.rst;
    EN           = v.en;
    CFG_VALID    = v.vld;
    CFG_PRESCALE = v.pre;
    e.tick  = v.tick;
    e.rdy   = v.rdy;
    e.ratio = v.ratio;
    e.err   = v.err;
    e.idx   = step;
    sb.push_back(e);
    step++;
    @(posedge CLK);
    @(negedge CLK);
    e = sb.pop_front();
    chk("tick",      e.idx, {7'b0, TICK},      {7'b0, e.tick});
    chk("cfg_ready", e.idx, {7'b0, CFG_READY}, {7'b0, e.rdy});
    chk("div_ratio", e.idx, DIV_RATIO,         e.ratio);
    chk("cfg_err",   e.idx, {7'b0, CFG_ERR},   {7'b0, e.err});
  endtask

  initial begin
    //                rst en vld pre         tick rdy ratio err
    tbl[0]  = mk(1, 0, 0, 'b000000, 0, 1, 1, 0);
    tbl[1]  = mk(0, 0, 1, 'b001000, 0, 1, 4, 0);
    tbl[2]  = mk(0, 0, 0, 'b000000, 0, 1, 4, 0);
    tbl[3]  = mk(0, 1, 0, 'b000000, 0, 1, 4, 0);
    tbl[4]  = mk(0, 1, 0, 'b000000, 0, 1, 4, 0);
    tbl[5]  = mk(0, 1, 0, 'b000000, 0, 1, 4, 0);
    tbl[6]  = mk(0, 1, 0, 'b000000, 1, 1, 4, 0);
    tbl[7]  = mk(0, 1, 0, 'b000000, 0, 1, 4, 0);
    tbl[8]  = mk(0, 1, 0, 'b000000, 0, 1, 4, 0);
    tbl[9]  = mk(0, 1, 0, 'b000000, 0, 1, 4, 0);
    tbl[10] = mk(0, 1, 0, 'b000000, 1, 1, 4, 0);
    tbl[11] = mk(0, 1, 1, 'b000100, 0, 1, 8, 0);
    tbl[12] = mk(0, 1, 0, 'b000000, 0, 1, 8, 0);
    tbl[13] = mk(0, 1, 0, 'b000000, 0, 1, 8, 0);
    tbl[14] = mk(0, 1, 1, 'b010000, 0, 0, 8, 0);
    tbl[15] = mk(0, 1, 1, 'b100000, 0, 0, 8, 0);
    tbl[16] = mk(0, 1, 0, 'b000000, 0, 0, 8, 0);
    tbl[17] = mk(0, 1, 0, 'b000000, 0, 0, 8, 0);
    tbl[18] = mk(0, 1, 0, 'b000000, 1, 0, 8, 0);
    tbl[19] = mk(0, 1, 0, 'b000000, 0, 1, 2, 0);
    tbl[20] = mk(0, 1, 0, 'b000000, 1, 1, 2, 0);
    tbl[21] = mk(0, 1, 0, 'b000000, 0, 1, 2, 0);
    tbl[22] = mk(0, 1, 0, 'b000000, 1, 1, 2, 0);
    tbl[23] = mk(0, 1, 1, 'b100000, 1, 1, 1, 0);
    tbl[24] = mk(0, 1, 0, 'b000000, 1, 1, 1, 0);
    tbl[25] = mk(0, 1, 0, 'b000000, 1, 1, 1, 0);
    tbl[26] = mk(0, 1, 1, 'b110000, 1, 1, 1, 1);
    tbl[27] = mk(0, 1, 0, 'b000000, 1, 1, 1, 0);
    tbl[28] = mk(0, 1, 1, 'b000000, 1, 1, 1, 1);
    tbl[29] = mk(0, 1, 0, 'b000000, 1, 1, 1, 0);
    tbl[30] = mk(0, 0, 0, 'b000000, 0, 1, 1, 0);

    @(negedge CLK);
    for (int i = 0; i < 31; i++) apply(tbl[i]);

    // Disable while a change is pending: shadow ratio lands, first period of the new ratio is whole.
    apply(mk(0, 0, 1, 'b001000, 0, 1, 4, 0));
    apply(mk(0, 1, 0, 'b000000, 0, 1, 4, 0));
    apply(mk(0, 1, 1, 'b010000, 0, 0, 4, 0));
    apply(mk(0, 0, 0, 'b000000, 0, 1, 2, 0));
    apply(mk(0, 1, 0, 'b000000, 0, 1, 2, 0));
    apply(mk(0, 1, 0, 'b000000, 1, 1, 2, 0));
    apply(mk(0, 0, 0, 'b000000, 0, 1, 2, 0));

    // Reset asserted mid-cycle while pending ratio 8: shadow must be discarded.
    apply(mk(0, 1, 0, 'b000000, 0, 1, 2, 0));
    apply(mk(0, 1, 1, 'b000100, 1, 0, 2, 0));
    #1 RST = 1'b1;
    #1;
    chk("async_rst_tick",  step, {7'b0, TICK},      8'd0);
    chk("async_rst_ready", step, {7'b0, CFG_READY}, 8'd1);
    chk("async_rst_ratio", step, DIV_RATIO,         8'd1);
    chk("async_rst_err",   step, {7'b0, CFG_ERR},   8'd0);
    #1 RST = 1'b0;
    #1;
    chk("post_rst_tick",  step, {7'b0, TICK}, 8'd0);
    chk("post_rst_ratio", step, DIV_RATIO,    8'd1);
    apply(mk(0, 1, 0, 'b000000, 1, 1, 1, 0));
    apply(mk(0, 1, 0, 'b000000, 1, 1, 1, 0));

    n_chk++;
    if (sb.size() == 0) n_pass++;
    else $display("FAIL scoreboard_drain: got %0d entries expected 0", sb.size());

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
